// File: rtl/mem_test_pkg.sv
// Shared types and helpers for the SDRAM test engine.
// Latency: none (types, constants and a constant function only).
// Backpressure: not applicable.
//
// Contents: FSM state enum, pattern mode encodings, and the checkerboard
// word generator used to build the alternating-bit constants.
package mem_test_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_WRITE = 3'd1,
    ST_READ  = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } state_t;

  typedef enum logic [1:0] {
    MODE_ADDR = 2'd0,
    MODE_INV  = 2'd1,
    MODE_WALK = 2'd2,
    MODE_CHK  = 2'd3
  } mode_t;

  // Widest data bus the checkerboard generator supports.
  localparam int MAX_DATA_W = 256;

  // Alternating-bit word. For odd=0 the odd bit positions are set
  // (...1010, MSB set for even widths); for odd=1 the even positions are set.
  function automatic logic [MAX_DATA_W-1:0] chk_word(input logic odd);
    logic [MAX_DATA_W-1:0] w;
    w = '0;
    for (int i = 0; i < MAX_DATA_W; i++) begin
      w[i] = (i % 2 == 1) ^ odd;
    end
    return w;
  endfunction

endpackage

// File: rtl/mem_test_engine_if.sv
// Avalon-like request/wait/valid bundle between the test engine and the SDRAM controller.
// Latency: wires only.
// Backpressure: mem_wait holds a presented request; mem_valid returns read data in order.
//
// master: engine side (drives request, address, write data, byte enables)
// slave : controller side (drives wait, read valid, read data)
interface mem_test_engine_if #(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
);
  logic                  mem_req;
  logic                  mem_wr_n;
  logic [DATA_W/8-1:0]   mem_be_n;
  logic [ADDR_W-1:0]     mem_addr;
  logic [DATA_W-1:0]     mem_wdata;
  logic                  mem_wait;
  logic                  mem_valid;
  logic [DATA_W-1:0]     mem_rdata;

  modport master (
    output mem_req, mem_wr_n, mem_be_n, mem_addr, mem_wdata,
    input  mem_wait, mem_valid, mem_rdata
  );

  modport slave (
    input  mem_req, mem_wr_n, mem_be_n, mem_addr, mem_wdata,
    output mem_wait, mem_valid, mem_rdata
  );
endinterface

// File: rtl/mem_test_pattern.sv
// Test pattern generator: maps (mode, word address) to the data word for that address.
// Latency: purely combinational.
// Backpressure: none.
//
// Ports: mode (pattern select), addr (word address), data (pattern word).
module mem_test_pattern
  import mem_test_pkg::*;
#(
  parameter int ADDR_W = 22,
  parameter int DATA_W = 16
) (
  input  mode_t             mode,
  input  logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] data
);

  localparam int SH_W = $clog2(DATA_W);
  localparam logic [DATA_W-1:0] CHK_EVEN = DATA_W'(chk_word(1'b0));
  localparam logic [DATA_W-1:0] CHK_ODD  = DATA_W'(chk_word(1'b1));
  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

  logic [DATA_W-1:0] addr_ext;
  logic              unused_addr;

  // Truncates or zero-extends depending on the relative widths.
  assign addr_ext    = DATA_W'(addr);
  // Upper address bits only matter when ADDR_W <= DATA_W.
  assign unused_addr = ^addr;

  always_comb begin
    data = addr_ext;
    case (mode)
      MODE_ADDR: data = addr_ext;
      MODE_INV:  data = ~addr_ext;
      // DATA_W is a power of two, so the low bits are exactly a mod DATA_W.
      MODE_WALK: data = ONE << addr[SH_W-1:0];
      MODE_CHK:  data = addr[0] ? CHK_ODD : CHK_EVEN;
      default:   data = addr_ext;
    endcase
  end

endmodule

// File: rtl/mem_test_engine.sv
// SDRAM test engine: writes a pattern over [addr_lo, addr_hi], reads it back pipelined, counts mismatches.
// Latency: first request on the cycle after start; done one cycle after the last read returns.
// Backpressure: mem_wait stalls the presented request; reads in flight capped at MAX_OUTST.
//
// Ports: clk, rst_n; start/mode/addr_lo/addr_hi (test setup, sampled in IDLE/DONE);
// mem (master side of the controller bus); busy/done/pass status;
// err_count (saturating), first_err_addr/first_err_data (first mismatch).
module mem_test_engine
  import mem_test_pkg::*;
#(
  parameter int ADDR_W    = 22,
  parameter int DATA_W    = 16,
  parameter int MAX_OUTST = 4,
  parameter int ERR_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic [1:0]        mode,
  input  logic [ADDR_W-1:0] addr_lo,
  input  logic [ADDR_W-1:0] addr_hi,
  mem_test_engine_if.master mem,
  output logic              busy,
  output logic              done,
  output logic              pass,
  output logic [ERR_W-1:0]  err_count,
  output logic [ADDR_W-1:0] first_err_addr,
  output logic [DATA_W-1:0] first_err_data
);

  localparam int OUT_W = $clog2(MAX_OUTST + 1);
  localparam logic [OUT_W-1:0] OUT_MAX = OUT_W'(MAX_OUTST);

  state_t            state_q, state_d;
  mode_t             mode_q;
  logic [ADDR_W-1:0] lo_q, hi_q;
  logic [ADDR_W-1:0] addr_q;       // address of the presented request
  logic [ADDR_W-1:0] ret_addr_q;   // address the next read return belongs to
  logic [OUT_W-1:0]  outst_q;
  logic [ERR_W-1:0]  err_q;
  logic [ADDR_W-1:0] ferr_addr_q;
  logic [DATA_W-1:0] ferr_data_q;
  logic              done_q, pass_q;

  logic [DATA_W-1:0] wr_pat, exp_pat;
  logic              req, accept, acc_rd, at_hi, start_ok, range_bad;
  logic              rd_ret, mismatch;

  mem_test_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_wr_pat (
    .mode (mode_q),
    .addr (addr_q),
    .data (wr_pat)
  );

  mem_test_pattern #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) u_exp_pat (
    .mode (mode_q),
    .addr (ret_addr_q),
    .data (exp_pat)
  );

  assign start_ok  = start && (state_q == ST_IDLE || state_q == ST_DONE);
  assign range_bad = addr_hi < addr_lo;
  // Last-address test is done on the current address, so a full-range
  // window ends without ever relying on the counter wrapping.
  assign at_hi     = (addr_q == hi_q);

  // Request is a pure function of registered state: an asserted reset
  // drops it immediately.
  assign req    = (state_q == ST_WRITE) ||
                  (state_q == ST_READ && outst_q < OUT_MAX);
  assign accept = req && !mem.mem_wait;
  assign acc_rd = accept && (state_q == ST_READ);

  // Returns with nothing outstanding (e.g. stale data after a reset) are dropped.
  assign rd_ret   = mem.mem_valid && (outst_q != '0);
  assign mismatch = rd_ret && (mem.mem_rdata != exp_pat);

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_DONE: if (start) state_d = range_bad ? ST_DONE : ST_WRITE;
      ST_WRITE:         if (accept && at_hi) state_d = ST_READ;
      ST_READ:          if (accept && at_hi) state_d = ST_DRAIN;
      ST_DRAIN:         if (outst_q == '0) state_d = ST_DONE;
      default:          state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Reads in flight; simultaneous issue and return cancel out.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      outst_q <= '0;
    end else begin
      case ({acc_rd, rd_ret})
        2'b10:   outst_q <= outst_q + 1'b1;
        2'b01:   outst_q <= outst_q - 1'b1;
        default: outst_q <= outst_q;
      endcase
    end
  end

  // Test setup, address walking, checking and result registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q      <= MODE_ADDR;
      lo_q        <= '0;
      hi_q        <= '0;
      addr_q      <= '0;
      ret_addr_q  <= '0;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      done_q      <= 1'b0;
      pass_q      <= 1'b0;
    end else if (start_ok) begin
      mode_q      <= mode_t'(mode);
      lo_q        <= addr_lo;
      hi_q        <= addr_hi;
      addr_q      <= addr_lo;
      ret_addr_q  <= addr_lo;
      err_q       <= '0;
      ferr_addr_q <= '0;
      ferr_data_q <= '0;
      pass_q      <= 1'b0;
      // An empty window finishes on the very next cycle.
      done_q      <= range_bad;
    end else begin
      // After the last write the request address rewinds for the read pass;
      // after the last read the value is irrelevant (no more requests).
      if (accept) begin
        addr_q <= at_hi ? lo_q : addr_q + 1'b1;
      end

      if (rd_ret) begin
        ret_addr_q <= ret_addr_q + 1'b1;
      end

      if (mismatch) begin
        if (err_q != '1) err_q <= err_q + 1'b1;
        // The counter saturates and never returns to zero, so zero means
        // no mismatch has been captured yet.
        if (err_q == '0) begin
          ferr_addr_q <= ret_addr_q;
          ferr_data_q <= mem.mem_rdata;
        end
      end

      if (state_q == ST_DRAIN && outst_q == '0) begin
        done_q <= 1'b1;
        pass_q <= (err_q == '0);
      end
    end
  end

  assign mem.mem_req   = req;
  assign mem.mem_wr_n  = (state_q != ST_WRITE);
  assign mem.mem_be_n  = '0;
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = (state_q == ST_WRITE) ? wr_pat : '0;

  assign busy           = (state_q == ST_WRITE) || (state_q == ST_READ) ||
                          (state_q == ST_DRAIN);
  assign done           = done_q;
  assign pass           = pass_q;
  assign err_count      = err_q;
  assign first_err_addr = ferr_addr_q;
  assign first_err_data = ferr_data_q;

endmodule

// File: tb/tb_mem_test_engine.sv
// Testbench for mem_test_engine: SDRAM model with configurable wait/latency,
// write and result scoreboards popped by a monitor, directed test sequence.
module tb_mem_test_engine;
  import mem_test_pkg::*;

  localparam int AW = 22;
  localparam int DW = 16;
  localparam int EW = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [1:0]    mode = 2'd0;
  logic [AW-1:0] addr_lo = '0;
  logic [AW-1:0] addr_hi = '0;
  logic          busy, done, pass;
  logic [EW-1:0] err_count;
  logic [AW-1:0] first_err_addr;
  logic [DW-1:0] first_err_data;

  mem_test_engine_if #(.ADDR_W(AW), .DATA_W(DW)) mem_if ();

  mem_test_engine #(.ADDR_W(AW), .DATA_W(DW), .MAX_OUTST(4), .ERR_W(EW)) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .mode           (mode),
    .addr_lo        (addr_lo),
    .addr_hi        (addr_hi),
    .mem            (mem_if.master),
    .busy           (busy),
    .done           (done),
    .pass           (pass),
    .err_count      (err_count),
    .first_err_addr (first_err_addr),
    .first_err_data (first_err_data)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  // ---------------- scoreboards ----------------
  typedef struct { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
  typedef struct { logic [EW-1:0] err; logic ps; logic [AW-1:0] fa; logic [DW-1:0] fd; } res_t;
  wr_t  wr_exp_q[$];
  res_t res_exp_q[$];

  // ---------------- memory model ----------------
  typedef struct { logic [DW-1:0] d; int due; } rd_t;
  rd_t           rd_q[$];
  logic [DW-1:0] mem_arr [int];
  int  cyc = 0;
  int  rd_lat = 1;
  int  flip_addr = -1;
  int  stall_addr = -1, stall_len = 0, stall_left = 0, stall_hold = 0;
  bit  stall_done = 1'b1;
  int  infl = 0, max_infl = 0, req_viol = 0, req_cycles = 0, valid_cnt = 0;
  int  wr_cnt = 0, wr_first = 0, wr_last = 0;
  bit            snap_acc = 1'b0, snap_wr = 1'b0;
  logic [AW-1:0] snap_addr = '0;
  logic [DW-1:0] snap_wdata = '0;

  always @(negedge clk) begin
    rd_t r;
    cyc++;
    if (rd_q.size() > 0 && rd_q[0].due <= cyc) begin
      mem_if.mem_valid = 1'b1;
      mem_if.mem_rdata = rd_q[0].d;
      void'(rd_q.pop_front());
      valid_cnt++;
    end else begin
      mem_if.mem_valid = 1'b0;
      mem_if.mem_rdata = '0;
    end
    infl = rd_q.size() + (mem_if.mem_valid ? 1 : 0);
    if (infl > max_infl) max_infl = infl;
    if (mem_if.mem_req && mem_if.mem_wr_n && infl >= 4) req_viol++;
    if (mem_if.mem_req) req_cycles++;

    if (!stall_done && mem_if.mem_req && !mem_if.mem_wr_n && mem_if.mem_addr == AW'(stall_addr)) begin
      stall_left = stall_len;
      stall_done = 1'b1;
    end
    mem_if.mem_wait = (stall_left > 0);
    if (stall_left > 0) begin
      stall_left--;
      if (mem_if.mem_req && !mem_if.mem_wr_n && mem_if.mem_addr == 22'h11 &&
          mem_if.mem_wdata == 16'h0002) stall_hold++;
    end

    snap_acc   = mem_if.mem_req && !mem_if.mem_wait;
    snap_wr    = !mem_if.mem_wr_n;
    snap_addr  = mem_if.mem_addr;
    snap_wdata = mem_if.mem_wdata;
    if (snap_acc) begin
      if (snap_wr) begin
        mem_arr[int'(snap_addr)] = snap_wdata;
        if (wr_cnt == 0) wr_first = cyc;
        wr_last = cyc;
        wr_cnt++;
      end else begin
        r.d   = mem_arr.exists(int'(snap_addr)) ? mem_arr[int'(snap_addr)] : '0;
        if (int'(snap_addr) == flip_addr) r.d = r.d ^ 16'h0001;
        r.due = cyc + rd_lat;
        rd_q.push_back(r);
      end
    end
  end

  // ---------------- monitor ----------------
  bit done_prev = 1'b0;
  always @(posedge clk) begin
    wr_t  w;
    res_t e;
    #1;
    if (rst_n) begin
      if (snap_acc && snap_wr) begin
        if (wr_exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL wr_unexpected: got write addr 0x%0h, required none", snap_addr);
        end else begin
          w = wr_exp_q.pop_front();
          check("wr_addr", 64'(snap_addr), 64'(w.a));
          check("wr_data", 64'(snap_wdata), 64'(w.d));
        end
      end
      if (done && !done_prev) begin
        if (res_exp_q.size() == 0) begin
          n_checks++;
          $display("FAIL done_unexpected: got done=1, required no result pending");
        end else begin
          e = res_exp_q.pop_front();
          check("res_err_count", 64'(err_count), 64'(e.err));
          check("res_pass", 64'(pass), 64'(e.ps));
          check("res_first_addr", 64'(first_err_addr), 64'(e.fa));
          check("res_first_data", 64'(first_err_data), 64'(e.fd));
        end
      end
    end
    done_prev = done;
  end

  // ---------------- stimulus helpers ----------------
  function automatic logic [DW-1:0] pat(input int m, input int a);
    logic [15:0] a16;
    a16 = a[15:0];
    case (m)
      0:       return a16;
      1:       return ~a16;
      2:       return 16'h0001 << a16[3:0];
      default: return a16[0] ? 16'h5555 : 16'hAAAA;
    endcase
  endfunction

  task automatic push_writes(input int m, input int lo, input int hi);
    wr_t w;
    for (int a = lo; a <= hi; a++) begin
      w.a = AW'(a);
      w.d = pat(m, a);
      wr_exp_q.push_back(w);
    end
  endtask

  task automatic push_res(input int err, input bit ps, input int fa, input int fd);
    res_t e;
    e.err = EW'(err); e.ps = ps; e.fa = AW'(fa); e.fd = DW'(fd);
    res_exp_q.push_back(e);
  endtask

  task automatic pulse_start(input int m, input int lo, input int hi);
    @(negedge clk);
    mode = 2'(m); addr_lo = AW'(lo); addr_hi = AW'(hi); start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_done(input string name, output int waited);
    waited = 0;
    while (!done && waited < 3000) begin
      @(negedge clk);
      waited++;
    end
    if (!done) begin
      n_checks++;
      $display("FAIL %s_timeout: got done=0 after %0d cycles, required done=1", name, waited);
    end
  endtask

  // ---------------- test sequence ----------------
  initial begin
    int w;
    bit found;

    #12;
    check("rst_mem_req", 64'(mem_if.mem_req), 64'd0);
    check("rst_mem_wr_n", 64'(mem_if.mem_wr_n), 64'd1);
    check("rst_mem_addr", 64'(mem_if.mem_addr), 64'd0);
    check("rst_status", 64'({busy, done, pass}), 64'd0);
    check("rst_err_count", 64'(err_count), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Empty window: done on the cycle after start, never a request.
    req_cycles = 0;
    push_res(0, 1'b0, 0, 0);
    pulse_start(0, 'h20, 'h1F);
    wait_done("t5", w);
    check("t5_done_latency", 64'(w), 64'd0);
    check("t5_pass", 64'(pass), 64'd0);
    repeat (3) @(negedge clk);
    check("t5_req_cycles", 64'(req_cycles), 64'd0);

    // Address pattern, clean memory.
    rd_lat = 1; wr_cnt = 0;
    push_writes(0, 'h10, 'h13);
    push_res(0, 1'b1, 0, 0);
    pulse_start(0, 'h10, 'h13);
    wait_done("t1", w);
    check("t1_write_burst_span", 64'(wr_last - wr_first), 64'd3);
    check("t1_write_count", 64'(wr_cnt), 64'd4);

    // Bit 0 flipped on the read of 0x12.
    flip_addr = 'h12;
    push_writes(0, 'h10, 'h13);
    push_res(1, 1'b0, 'h12, 'h0013);
    pulse_start(0, 'h10, 'h13);
    wait_done("t2", w);
    flip_addr = -1;

    // Walking one with a 5-cycle stall on the write of 0x11.
    stall_addr = 'h11; stall_len = 5; stall_hold = 0; stall_done = 1'b0;
    push_writes(2, 'h10, 'h13);
    push_res(0, 1'b1, 0, 0);
    pulse_start(2, 'h10, 'h13);
    wait_done("t3", w);
    check("t3_stall_hold_cycles", 64'(stall_hold), 64'd5);
    check("t3_mem_10", 64'(mem_arr['h10]), 64'h0001);
    check("t3_mem_11", 64'(mem_arr['h11]), 64'h0002);
    check("t3_mem_12", 64'(mem_arr['h12]), 64'h0004);
    check("t3_mem_13", 64'(mem_arr['h13]), 64'h0008);

    // Long read latency: outstanding limit must throttle requests.
    rd_lat = 10; max_infl = 0; req_viol = 0; valid_cnt = 0;
    push_writes(3, 0, 15);
    push_res(0, 1'b1, 0, 0);
    pulse_start(3, 0, 15);
    wait_done("t4", w);
    check("t4_max_inflight", 64'(max_infl), 64'd4);
    check("t4_req_at_limit", 64'(req_viol), 64'd0);
    check("t4_read_returns", 64'(valid_cnt), 64'd16);

    // Reset in the middle of the read pass at address 0x05.
    rd_lat = 4;
    push_writes(1, 0, 7);
    pulse_start(1, 0, 7);
    found = 1'b0;
    for (int i = 0; i < 200; i++) begin
      if (mem_if.mem_req && mem_if.mem_wr_n && mem_if.mem_addr == 22'h05) begin
        found = 1'b1;
        break;
      end
      @(negedge clk);
    end
    check("t6_reached_read_5", 64'(found), 64'd1);
    #1 rst_n = 1'b0;
    #1;
    check("t6_rst_mem_req", 64'(mem_if.mem_req), 64'd0);
    check("t6_rst_mem_wr_n", 64'(mem_if.mem_wr_n), 64'd1);
    check("t6_rst_mem_addr", 64'(mem_if.mem_addr), 64'd0);
    check("t6_rst_status", 64'({busy, done, pass}), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (15) @(negedge clk);
    check("t6_stale_err_count", 64'(err_count), 64'd0);
    check("t6_stale_status", 64'({busy, done}), 64'd0);
    push_writes(1, 0, 7);
    push_res(0, 1'b1, 0, 0);
    pulse_start(1, 0, 7);
    wait_done("t6", w);
    check("t6_rerun_pass", 64'(pass), 64'd1);

    repeat (3) @(negedge clk);
    check("wr_queue_drained", 64'(wr_exp_q.size()), 64'd0);
    check("res_queue_drained", 64'(res_exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
